// File: rtl/conv_pkg.sv
// Shared types and default geometry for the line-buffer controller.
// The default geometry is one 4-pixel FIFO row and 3 rows per frame.
package conv_pkg;

    localparam int DEF_IMG_W     = 4;
    localparam int DEF_IMG_H     = 3;
    localparam int DEF_ADD_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FILL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/conv_cnt.sv
// Mod-N counter with enable, synchronous clear and wrap flag.
// wrap_o fires on the enabled cycle that takes the count from N-1 back to 0.
module conv_cnt #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(N - 1));
    assign wrap_o = en_i & at_max;
    assign cnt_o  = cnt_q;

    // next count: clear wins over enable, wrap at N-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    // count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Controller that turns an external FIFO into a one-row delay line.
// Frame: clear pointers, fill one row, stream write+read, drain last row.
module line_buf_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int ADD_WIDTH = DEF_ADD_WIDTH,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    output logic wr_en,
    output logic wr_inc,
    output logic wr_clr,
    output logic rd_en,
    output logic rd_inc,
    output logic rd_clr,
    output logic win_valid,
    output logic row_last,
    output logic busy,
    output logic done
);

    // the drain empties the whole FIFO, whose depth is the pointer range
    localparam int DEPTH = 1 << ADD_WIDTH;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] row_cnt;
    logic             col_en;
    logic             col_wrap;
    logic             row_en;
    logic             row_wrap;
    logic             clr;
    logic             win_valid_q;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode; start only matters while idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_FILL;
            ST_FILL:   if (col_wrap && row_cnt == '0) state_d = ST_STREAM;
            ST_STREAM: if (row_wrap) state_d = ST_DRAIN;
            ST_DRAIN:  if (col_cnt == CNT_W'(DEPTH - 1)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // output decode; a missing in_valid stalls with every enable low
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_CLEAR: clr = 1'b1;
            ST_FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
            end
            ST_STREAM: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                rd_en    = in_valid;
            end
            ST_DRAIN: rd_en = 1'b1;
            ST_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    assign wr_inc   = wr_en;
    assign rd_inc   = rd_en;
    assign wr_clr   = clr;
    assign rd_clr   = clr;
    assign row_last = wr_en && (col_cnt == CNT_W'(IMG_W - 1));

    // columns also pace the drain; rows only advance on accepted pixels
    assign col_en = wr_en | (state_q == ST_DRAIN);
    assign row_en = col_wrap & in_ready;

    conv_cnt #(
        .N (IMG_W),
        .W (CNT_W)
    ) u_col_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .en_i   (col_en),
        .cnt_o  (col_cnt),
        .wrap_o (col_wrap)
    );

    conv_cnt #(
        .N (IMG_H),
        .W (CNT_W)
    ) u_row_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .en_i   (row_en),
        .cnt_o  (row_cnt),
        .wrap_o (row_wrap)
    );

    // win_valid tracks the FIFO's registered read, one cycle behind rd_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= rd_en;
        end
    end

    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl driving a small FIFO model.
// Expectations come from a pixel-count frame model and a data queue.
module tb_line_buf_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HW = W * H;

    logic clk = 1'b0;
    logic rst_n, start, in_valid;
    logic in_ready, wr_en, wr_inc, wr_clr, rd_en, rd_inc, rd_clr;
    logic win_valid, row_last, busy, done;

    always #5 clk = ~clk;

    line_buf_ctrl #(
        .IMG_W     (W),
        .IMG_H     (H),
        .ADD_WIDTH (2),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_inc    (wr_inc),
        .wr_clr    (wr_clr),
        .rd_en     (rd_en),
        .rd_inc    (rd_inc),
        .rd_clr    (rd_clr),
        .win_valid (win_valid),
        .row_last  (row_last),
        .busy      (busy),
        .done      (done)
    );

    // FIFO with registered read; pointers only move on DUT commands
    logic [7:0] mem [W];
    logic [1:0] wp, rp;
    logic [7:0] data_out, pix;

    always @(posedge clk) begin
        if (wr_clr) wp <= '0;
        else if (wr_en) begin
            mem[wp] <= pix;
            if (wr_inc) wp <= wp + 2'd1;
        end
        if (rd_clr) rp <= '0;
        else if (rd_en) begin
            data_out <= mem[rp];
            if (rd_inc) rp <= rp + 2'd1;
        end
    end

    int errors = 0;
    int checks = 0;

    // frame model: active, clear pending, pixels accepted, drain reads
    bit m_act = 0, m_clr = 0, m_wv = 0;
    int m_acc = 0, m_drn = 0;
    logic [7:0] q[$];
    logic prev_rd = 1'b0;
    int nwr = 0, nrd = 0;
    bit seen_done;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit st, input bit iv, input bit rn,
                        input bit ramp);
        bit acc_ok, e_wr, e_rd, e_drain, e_done, e_last, e_clr;
        logic obs_rd;
        @(negedge clk);
        start    = st;
        in_valid = iv;
        rst_n    = rn;
        pix      = ramp ? 8'(m_acc) : 8'($urandom_range(0, 255));
        #1;
        acc_ok  = m_act && !m_clr && (m_acc < HW);
        e_wr    = acc_ok && iv;
        e_drain = m_act && !m_clr && (m_acc == HW) && (m_drn < W);
        e_rd    = (e_wr && m_acc >= W) || e_drain;
        e_done  = m_act && (m_acc == HW) && (m_drn == W);
        e_last  = e_wr && ((m_acc % W) == W - 1);
        e_clr   = m_act && m_clr;
        check("in_ready", in_ready, acc_ok);
        check("wr_en", wr_en, e_wr);
        check("wr_inc", wr_inc, e_wr);
        check("rd_en", rd_en, e_rd);
        check("rd_inc", rd_inc, e_rd);
        check("wr_clr", wr_clr, e_clr);
        check("rd_clr", rd_clr, e_clr);
        check("row_last", row_last, e_last);
        check("busy", busy, m_act);
        check("done", done, e_done);
        check("win_valid", win_valid, m_wv);
        check("wv_is_rd_delayed", win_valid, prev_rd);
        check("wr_and_clr", wr_en & wr_clr, 1'b0);
        check("rd_and_clr", rd_en & rd_clr, 1'b0);
        if (m_wv) begin
            if (q.size() == 0) check("data_underflow", 1, 0);
            else check("data_out", data_out, q.pop_front());
        end
        if (e_clr) begin
            nwr = 0;
            nrd = 0;
        end
        nwr += int'(wr_en);
        nrd += int'(rd_en);
        if (e_done) begin
            check("frame_wr_count", nwr, HW);
            check("frame_rd_count", nrd, HW);
        end
        seen_done = done;
        obs_rd = rd_en;
        @(posedge clk);
        prev_rd = obs_rd;
        if (!rn) begin
            m_act = 0; m_clr = 0; m_acc = 0; m_drn = 0; m_wv = 0;
            prev_rd = 1'b0;
            q.delete();
        end else begin
            m_wv = e_rd;
            if (e_wr) begin
                q.push_back(pix);
                m_acc++;
            end
            if (!m_act) begin
                if (st) begin m_act = 1; m_clr = 1; end
            end else if (m_clr) m_clr = 0;
            else if (e_drain) m_drn++;
            else if (e_done) begin
                m_act = 0; m_acc = 0; m_drn = 0;
            end
        end
    endtask

    // mode 0: in_valid high, 1: toggling, 2: random valid, data, starts
    task automatic run_frame(input int mode, output int done_at);
        int ndone;
        bit iv, st;
        ndone   = 0;
        done_at = -1;
        step(1'b1, 1'b1, 1'b1, mode != 2);
        for (int i = 1; i < 200; i++) begin
            iv = (mode == 0) ? 1'b1 :
                 (mode == 1) ? 1'(i & 1) : 1'($urandom_range(0, 3) != 0);
            st = (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
            step(st, iv, 1'b1, mode != 2);
            if (seen_done) begin
                ndone++;
                done_at = i;
                break;
            end
        end
        if (done_at < 0) check("frame_timeout", 0, 1);
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (seen_done) ndone++;
        end
        check("done_pulses", ndone, 1);
    endtask

    initial begin
        int t;
        start    = 1'b0;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        pix      = '0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        run_frame(0, t);
        check("done_cycle", t, 18);
        run_frame(1, t);
        run_frame(2, t);

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        run_frame(0, t);
        check("done_cycle_after_reset", t, 18);

        repeat (4) run_frame(2, t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
